// File: rtl/aes128_pkg.sv
// Shared constants and helpers for the iterative AES-128 encryption engine:
// round count, FSM encoding, S-box, Rcon and GF(2^8) column mixing.
package aes128_pkg;

    localparam logic [3:0] NR = 4'd10;

    typedef enum logic {
        IDLE,
        RUN
    } aesFsm_e;

    // Entry x lives at bits [8*(255-x) +: 8], so row 0 byte 0 (0x63) is the MSB byte.
    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] x);
        return SBOX[{~x, 3'b000} +: 8];
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] r);
        case (r)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] mixColumn(input logic [31:0] col);
        logic [7:0] a0, a1, a2, a3;
        a0 = col[31:24];
        a1 = col[23:16];
        a2 = col[15:8];
        a3 = col[7:0];
        return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    endfunction

    // LSB position of state byte (row, col); byte index is col*4+row, MSB-first.
    function automatic int byteLsb(input int row, input int col);
        return 120 - 8 * (col * 4 + row);
    endfunction

endpackage

// File: rtl/aes128_round.sv
// Purely combinational AES-128 round: SubBytes, ShiftRows, optional MixColumns,
// AddRoundKey, plus derivation of this round's key from the previous one.
module aes128_round
    import aes128_pkg::*;
(
    input  logic [127:0] state_i,
    input  logic [127:0] roundKey_i,
    input  logic [7:0]   rcon_i,
    input  logic         lastRound_i,
    output logic [127:0] state_o,
    output logic [127:0] roundKey_o
);

    logic [127:0] shifted;
    logic [127:0] mixed;
    logic [31:0]  keyTemp;
    logic [31:0]  w0, w1, w2, w3;

    always_comb begin
        shifted = '0;
        mixed   = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                shifted[byteLsb(r, c) +: 8] = sbox(state_i[byteLsb(r, (c + r) % 4) +: 8]);
            end
        end
        for (int c = 0; c < 4; c++) begin
            mixed[96 - 32 * c +: 32] = mixColumn(shifted[96 - 32 * c +: 32]);
        end
    end

    // RotWord then SubWord on the last word, then Rcon into the top byte.
    assign keyTemp = {sbox(roundKey_i[23:16]), sbox(roundKey_i[15:8]),
                      sbox(roundKey_i[7:0]),   sbox(roundKey_i[31:24])} ^ {rcon_i, 24'h0};

    assign w0 = roundKey_i[127:96] ^ keyTemp;
    assign w1 = roundKey_i[95:64]  ^ w0;
    assign w2 = roundKey_i[63:32]  ^ w1;
    assign w3 = roundKey_i[31:0]   ^ w2;

    assign roundKey_o = {w0, w1, w2, w3};
    assign state_o    = (lastRound_i ? shifted : mixed) ^ roundKey_o;

endmodule

// File: rtl/aes128_enc.sv
// Iterative AES-128 encryption, one round per clock with on-the-fly key expansion.
// Define AES128_ROUND_DBG_EN to expose dbg_round and dbg_state.
module aes128_enc
    import aes128_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [127:0] plaintext,
    input  logic [127:0] key,
    output logic         busy,
    output logic         done,
    output logic [127:0] ciphertext
`ifdef AES128_ROUND_DBG_EN
    ,
    output logic [3:0]   dbg_round,
    output logic [127:0] dbg_state
`endif
);

    aesFsm_e      fsm_q, fsm_d;
    logic [3:0]   round_q, round_d;
    logic [127:0] state_q, state_d;
    logic [127:0] roundKey_q, roundKey_d;
    logic [127:0] ciphertext_q, ciphertext_d;
    logic         done_q, done_d;

    logic [127:0] roundState;
    logic [127:0] roundKeyNext;

    aes128_round uRound (
        .state_i     (state_q),
        .roundKey_i  (roundKey_q),
        .rcon_i      (rcon(round_q)),
        .lastRound_i (round_q == NR),
        .state_o     (roundState),
        .roundKey_o  (roundKeyNext)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fsm_q        <= IDLE;
            round_q      <= '0;
            state_q      <= '0;
            roundKey_q   <= '0;
            ciphertext_q <= '0;
            done_q       <= 1'b0;
        end else begin
            fsm_q        <= fsm_d;
            round_q      <= round_d;
            state_q      <= state_d;
            roundKey_q   <= roundKey_d;
            ciphertext_q <= ciphertext_d;
            done_q       <= done_d;
        end
    end

    always_comb begin
        fsm_d        = fsm_q;
        round_d      = round_q;
        state_d      = state_q;
        roundKey_d   = roundKey_q;
        ciphertext_d = ciphertext_q;
        done_d       = 1'b0;
        case (fsm_q)
            IDLE: begin
                if (start) begin
                    state_d    = plaintext ^ key;
                    roundKey_d = key;
                    round_d    = 4'd1;
                    fsm_d      = RUN;
                end
            end
            RUN: begin
                state_d    = roundState;
                roundKey_d = roundKeyNext;
                if (round_q == NR) begin
                    ciphertext_d = roundState;
                    done_d       = 1'b1;
                    round_d      = '0;
                    fsm_d        = IDLE;
                end else begin
                    round_d = round_q + 4'd1;
                end
            end
            default: fsm_d = IDLE;
        endcase
    end

    assign busy       = (fsm_q == RUN);
    assign done       = done_q;
    assign ciphertext = ciphertext_q;

`ifdef AES128_ROUND_DBG_EN
    assign dbg_round = round_q;
    assign dbg_state = state_q;
`endif

endmodule

// File: tb/tb_aes128_enc.sv
// Directed known-answer bench for aes128_enc: FIPS-197 vectors, latency,
// busy/ignore rules, back-to-back operation, mid-run reset and input changes.
module tb_aes128_enc;

    localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] Z_CT   = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;
    localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [127:0] plaintext;
    logic [127:0] key;
    logic         busy;
    logic         done;
    logic [127:0] ciphertext;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    aes128_enc dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .plaintext  (plaintext),
        .key        (key),
        .busy       (busy),
        .done       (done),
        .ciphertext (ciphertext)
    );

    // Returns at the falling edge right after the accept edge.
    task automatic applyStimulus(input logic [127:0] pt, input logic [127:0] k);
        @(negedge clk);
        plaintext = pt;
        key       = k;
        start     = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic waitDone(input int limit, output int lat);
        lat = -1;
        for (int k = 1; k <= limit; k++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                lat = k;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        start     = 1'b0;
        plaintext = '0;
        key       = '0;
        repeat (2) @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_busy: got %b expected 0", busy);
        end
        checks++;
        if (done !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_done: got %b expected 0", done);
        end
        checks++;
        if (ciphertext !== 128'h0) begin
            failures++;
            $display("[TB] FAIL reset_ct: got %h expected 0", ciphertext);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_known_answer(input string name, input logic [127:0] pt,
                                     input logic [127:0] k, input logic [127:0] exp);
        int lat;
        applyStimulus(pt, k);
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("[TB] FAIL %s_busy: got %b expected 1", name, busy);
        end
        waitDone(20, lat);
        checks++;
        if (lat != 10) begin
            failures++;
            $display("[TB] FAIL %s_latency: got %0d expected 10", name, lat);
        end
        checks++;
        if (ciphertext !== exp) begin
            failures++;
            $display("[TB] FAIL %s_ct: got %h expected %h", name, ciphertext, exp);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0) begin
            failures++;
            $display("[TB] FAIL %s_done_width: got %b expected 0", name, done);
        end
    endtask

    task automatic test_busy_ignore();
        int lat;
        applyStimulus(B_PT, B_KEY);
        repeat (4) @(negedge clk);
        plaintext = '0;
        key       = '0;
        start     = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("[TB] FAIL ignore_busy: got %b expected 1", busy);
        end
        waitDone(20, lat);
        checks++;
        if (lat != 5) begin
            failures++;
            $display("[TB] FAIL ignore_latency: got %0d expected 5", lat);
        end
        checks++;
        if (ciphertext !== B_CT) begin
            failures++;
            $display("[TB] FAIL ignore_ct: got %h expected %h", ciphertext, B_CT);
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        int lat1;
        int lat2;
        @(negedge clk);
        plaintext = C1_PT;
        key       = C1_KEY;
        start     = 1'b1;
        @(negedge clk);
        plaintext = '0;
        key       = '0;
        waitDone(20, lat1);
        checks++;
        if (lat1 != 10) begin
            failures++;
            $display("[TB] FAIL b2b_first_latency: got %0d expected 10", lat1);
        end
        checks++;
        if (ciphertext !== C1_CT) begin
            failures++;
            $display("[TB] FAIL b2b_first_ct: got %h expected %h", ciphertext, C1_CT);
        end
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("[TB] FAIL b2b_done_busy: got %b expected 0", busy);
        end
        lat2 = -1;
        for (int k = 1; k <= 25; k++) begin
            @(negedge clk);
            if (k == 5) begin
                checks++;
                if (ciphertext !== C1_CT) begin
                    failures++;
                    $display("[TB] FAIL b2b_ct_hold: got %h expected %h", ciphertext, C1_CT);
                end
            end
            if (done === 1'b1) begin
                lat2 = k;
                break;
            end
        end
        start = 1'b0;
        checks++;
        if (lat2 != 11) begin
            failures++;
            $display("[TB] FAIL b2b_second_spacing: got %0d expected 11", lat2);
        end
        checks++;
        if (ciphertext !== Z_CT) begin
            failures++;
            $display("[TB] FAIL b2b_second_ct: got %h expected %h", ciphertext, Z_CT);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("[TB] FAIL b2b_idle_after: got %b expected 0", busy);
        end
    endtask

    task automatic test_reset_mid();
        int dones;
        int lat;
        applyStimulus(C1_PT, C1_KEY);
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("[TB] FAIL midreset_busy: got %b expected 0", busy);
        end
        checks++;
        if (done !== 1'b0) begin
            failures++;
            $display("[TB] FAIL midreset_done: got %b expected 0", done);
        end
        checks++;
        if (ciphertext !== 128'h0) begin
            failures++;
            $display("[TB] FAIL midreset_ct: got %h expected 0", ciphertext);
        end
        rst_n = 1'b1;
        dones = 0;
        for (int k = 0; k < 15; k++) begin
            @(negedge clk);
            if (done === 1'b1) dones++;
        end
        checks++;
        if (dones != 0) begin
            failures++;
            $display("[TB] FAIL midreset_no_done: got %0d expected 0", dones);
        end
        applyStimulus(C1_PT, C1_KEY);
        waitDone(20, lat);
        checks++;
        if (lat != 10 || ciphertext !== C1_CT) begin
            failures++;
            $display("[TB] FAIL midreset_restart: got lat=%0d ct=%h expected lat=10 ct=%h",
                     lat, ciphertext, C1_CT);
        end
        @(negedge clk);
    endtask

    task automatic test_input_change();
        int lat;
        applyStimulus(B_PT, B_KEY);
        plaintext = ~B_PT;
        key       = ~B_KEY;
        waitDone(20, lat);
        checks++;
        if (lat != 10) begin
            failures++;
            $display("[TB] FAIL inchange_latency: got %0d expected 10", lat);
        end
        checks++;
        if (ciphertext !== B_CT) begin
            failures++;
            $display("[TB] FAIL inchange_ct: got %h expected %h", ciphertext, B_CT);
        end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_known_answer("fips_c1", C1_PT, C1_KEY, C1_CT);
        test_known_answer("all_zero", 128'h0, 128'h0, Z_CT);
        test_known_answer("fips_b", B_PT, B_KEY, B_CT);
        test_busy_ignore();
        test_back_to_back();
        test_reset_mid();
        test_input_change();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
